btn_reader: RTL

- Input-side counterpart of the blink LED driver: samples an asynchronous push-button pin and delivers clean, debounced events to the design.
- Synchronises the pin, filters bounce with a timed state machine, and reports:
  - stable level
  - one-cycle press and release pulses
  - a one-cycle long-press pulse after the button has been held SECS seconds
- Sits between the board pin and user logic in the same top-level wrappers that instantiate the blinker; uses the same FREQ/SECS parameter style.

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_reader_sync2.sv | 22 ++
 rtl/btn_reader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button reader.
package btn_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    // Bits needed to hold any value in 0..max
    function automatic int unsigned cnt_width(input longint max);
        return unsigned'($clog2(max + 64'sd1));
    endfunction

endpackage

// File: rtl/btn_reader_sync2.sv
// Two-flop synchroniser for an asynchronous pin; reused for other pin inputs.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the raw pin, then re-register to settle metastability
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_reader.sv
// Debounced push-button reader: level, press/release pulses and a long-press pulse.
module btn_reader
    import btn_pkg::*;
#(
    parameter int unsigned FREQ   = 0,
    parameter int unsigned SECS   = 0,
    parameter int unsigned MSECS  = 10,
    parameter int unsigned INVERT = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam longint unsigned DB_CNT   = 64'(FREQ) / 64'd1000 * 64'(MSECS);
    localparam longint unsigned LONG_CNT = 64'(FREQ) * 64'(SECS);
    localparam int unsigned DB_W = (DB_CNT == 64'd0) ? 1 : cnt_width(longint'(DB_CNT));
    localparam int unsigned LG_W = (LONG_CNT == 64'd0) ? 1 : cnt_width(longint'(LONG_CNT));
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 64'd1);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CNT - 64'd1);

    // Reject unusable timing parameters at elaboration
    if (FREQ == 0) begin : g_bad_freq
        $error("btn_reader: FREQ must be overridden with a nonzero clock frequency");
    end
    if (SECS == 0) begin : g_bad_secs
        $error("btn_reader: SECS must be overridden with a nonzero hold time");
    end
    if (DB_CNT == 64'd0) begin : g_bad_db
        $error("btn_reader: debounce window FREQ/1000*MSECS must be nonzero");
    end

    logic            pin_sync;
    logic            s;
    state_t          state, state_n;
    logic [DB_W-1:0] db_cnt, db_cnt_n;
    logic [LG_W-1:0] long_cnt, long_cnt_n;
    logic            long_fired, long_fired_n;
    logic            level_n, press_n, release_n, long_n;

    sync2 u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (btn_i),
        .q     (pin_sync)
    );

    // Polarity-corrected, registered pin level used by every FSM decision
    always_ff @(posedge clk_i) begin
        if (rst_i) s <= 1'b0;
        else       s <= pin_sync ^ 1'(INVERT);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            db_cnt     <= '0;
            long_cnt   <= '0;
            long_fired <= 1'b0;
            level_o    <= 1'b0;
            press_o    <= 1'b0;
            release_o  <= 1'b0;
            long_o     <= 1'b0;
        end else begin
            state      <= state_n;
            db_cnt     <= db_cnt_n;
            long_cnt   <= long_cnt_n;
            long_fired <= long_fired_n;
            level_o    <= level_n;
            press_o    <= press_n;
            release_o  <= release_n;
            long_o     <= long_n;
        end
    end

    // Debounce transitions, long-press timing and next output values
    always_comb begin
        state_n      = state;
        db_cnt_n     = db_cnt;
        long_cnt_n   = long_cnt;
        long_fired_n = long_fired;
        level_n      = level_o;
        press_n      = 1'b0;
        release_n    = 1'b0;
        long_n       = 1'b0;

        case (state)
            IDLE: begin
                if (s) begin
                    state_n  = PRESS_WAIT;
                    db_cnt_n = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_n      = PRESSED;
                    press_n      = 1'b1;
                    level_n      = 1'b1;
                    long_cnt_n   = '0;
                    long_fired_n = 1'b0;
                end else begin
                    db_cnt_n = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n  = REL_WAIT;
                    db_cnt_n = '0;
                end
            end
            REL_WAIT: begin
                if (s) begin
                    state_n = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                    level_n   = 1'b0;
                end else begin
                    db_cnt_n = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Hold timer runs while pressed; a completing release suppresses the long pulse
        if ((state == PRESSED || state == REL_WAIT) && !release_n) begin
            if (long_cnt == LG_LAST) begin
                if (!long_fired) begin
                    long_n       = 1'b1;
                    long_fired_n = 1'b1;
                end
            end else begin
                long_cnt_n = long_cnt + LG_W'(1);
            end
        end
    end

endmodule
